serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller. It sequences one full-adder bit cell, built from two

---
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders plus an OR)
// iterated LSB-first over WIDTH cycles, with a start/busy/done handshake.
// The result is registered on entry to DONE and held until the next result or reset.

module halfadd (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, p_sh, p_next;
  logic             c;
  logic [CW-1:0]    cnt;

  logic hs1, hc1, hs2, hc2;
  logic bit_s, bit_co;
  logic accept, last_bit;

  // Bit cell: first half adder combines the operand bits, second adds the carry.
  halfadd u_ha0 (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .s (hs1),
    .c (hc1)
  );

  halfadd u_ha1 (
    .x (hs1),
    .y (c),
    .s (hs2),
    .c (hc2)
  );

  assign bit_s    = hs2;
  assign bit_co   = hc1 | hc2;
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == LAST);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // Partial sum after inserting the current bit at the MSB (shift-right form keeps WIDTH=1 legal).
  always_comb begin
    p_next          = p_sh >> 1;
    p_next[WIDTH-1] = bit_s;
  end

  // Next-state decode; start is only looked at in IDLE and DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last_bit ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: operand capture on accept, one bit per RUN edge, result capture on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      p_sh      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      p_sh <= '0;
      c    <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      p_sh <= p_next;
      c    <= bit_co;
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        sum       <= p_next;
        carry_out <= bit_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks for serial_add_ctrl at WIDTH=8.

module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_co;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one operation from an IDLE/DONE cycle and stop in the cycle where done is seen.
  // lat = edges after acceptance until done; bcnt = cycles with busy high.
  // With inject set, start is raised (zero operands) during RUN cycle 3.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit inject,
                        output int lat, output int bcnt);
    start = 1'b1;
    a     = oa;
    b     = ob;
    tick();
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      start = inject && (lat == 2);
      a     = start ? '0 : W'($urandom);
      b     = start ? '0 : W'($urandom);
      tick();
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bcnt, gap;
    logic [W:0] exp9;

    vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[1] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[3] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 8'h46, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", carry_out, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (done || busy) seen++;
      end
      chk("idle_no_activity", seen, 0);
    end

    // Table vectors, each followed by one idle cycle to check the pulse and the hold.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, lat, bcnt);
      chk($sformatf("v%0d_lat", i), lat, 8);
      chk($sformatf("v%0d_busy", i), bcnt, 8);
      chk($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
      chk($sformatf("v%0d_co", i), carry_out, vecs[i].exp_co);
      tick();
      chk($sformatf("v%0d_pulse", i), done, 0);
      chk($sformatf("v%0d_hold", i), {carry_out, sum}, {vecs[i].exp_co, vecs[i].exp_sum});
    end

    // start during RUN is ignored.
    run_op(8'h0F, 8'h01, 1'b1, lat, bcnt);
    chk("ign_lat", lat, 8);
    chk("ign_sum", sum, 8'h10);
    chk("ign_co", carry_out, 0);
    tick();
    chk("ign_no_restart", busy, 0);

    // rst in RUN cycle 4 aborts with no done pulse.
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_co", carry_out, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done || busy) seen++;
      end
      chk("abort_no_pulse", seen, 0);
    end
    run_op(8'h33, 8'h44, 1'b0, lat, bcnt);
    chk("after_abort_lat", lat, 8);
    chk("after_abort_sum", sum, 8'h77);

    // Back-to-back: start held in the DONE cycle.
    run_op(8'h7F, 8'h01, 1'b0, lat, bcnt);
    gap = lat + 1;
    chk("b2b_gap", gap, 9);
    chk("b2b_sum", sum, 8'h80);
    chk("b2b_co", carry_out, 0);

    // Random operands, issued back-to-back.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      ra   = W'($urandom);
      rb   = W'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, 1'b0, lat, bcnt);
      chk("rand_lat", lat, 8);
      chk("rand_res", {carry_out, sum}, exp9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
